i2s_data_axil_fifo: RTL

//  AXI4-Lite slave for the audio codec path, successor to the 4-register i2s_data slave.
//  - Places a parametrised TX sample FIFO and RX sample FIFO behind a 4-register map.
//  - TX FIFO drains over a valid/ready stream to the I2S serializer, with a channel index

---
 rtl/i2s_data_axil_fifo.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/i2s_data_axil_fifo.sv
// AXI4-Lite slave with TX/RX audio sample FIFOs for the codec serializer/deserializer.
// Optional interrupt output is built when I2S_DATA_IRQ_EN is defined; otherwise irq is tied 0.
module i2s_data_axil_fifo #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_SAMPLE_WIDTH     = 24,
  parameter int C_FIFO_DEPTH       = 16,
  parameter int C_NUM_CH           = 2,
  localparam int CW = (C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_SAMPLE_WIDTH-1:0]       tx_tdata,
  output logic [CW-1:0]                   tx_tchan,
  output logic                            tx_tvalid,
  input  logic                            tx_tready,
  input  logic [C_SAMPLE_WIDTH-1:0]       rx_tdata,
  input  logic                            rx_tvalid,
  output logic                            irq
);
  localparam int AW = $clog2(C_FIFO_DEPTH);

  logic [C_SAMPLE_WIDTH-1:0] tx_mem [C_FIFO_DEPTH];
  logic [C_SAMPLE_WIDTH-1:0] rx_mem [C_FIFO_DEPTH];
  logic [AW:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr, tx_level, rx_level;
  logic        tx_en, rx_en, tx_flush, rx_flush;
  logic [6:0]  irq_thresh;
  logic [3:0]  sticky;  // {axi_rx_unf, axi_tx_ovf, rx_overflow, tx_underrun}
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        wr_fire, rd_fire;
  logic [1:0]  wr_sel, rd_sel;
  logic        tx_push_req, tx_pop, tx_push, tx_drop;
  logic        rx_push_req, rx_pop, rx_push, rx_ovf, rx_unf, tx_unr;
  logic [3:0]  sticky_clr;
  logic [31:0] ctrl_word, status_word, rd_word;
  logic        unused;

  assign unused = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WSTRB, S_AXI_WDATA};

  assign tx_level = tx_wptr - tx_rptr;
  assign rx_level = rx_wptr - rx_rptr;
  // Level tops out at DEPTH = 2**AW, so the MSB alone flags full.
  assign tx_full  = tx_level[AW];
  assign rx_full  = rx_level[AW];
  assign tx_empty = (tx_level == '0);
  assign rx_empty = (rx_level == '0);

  assign wr_fire = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire = S_AXI_ARREADY & S_AXI_ARVALID;
  assign wr_sel  = S_AXI_AWADDR[3:2];
  assign rd_sel  = S_AXI_ARADDR[3:2];

  assign tx_tvalid   = tx_en & ~tx_empty;
  assign tx_tdata    = tx_mem[tx_rptr[AW-1:0]];
  assign tx_pop      = tx_tvalid & tx_tready;
  assign tx_push_req = wr_fire & (wr_sel == 2'd2);
  assign tx_push     = tx_push_req & (~tx_full | tx_pop) & ~tx_flush;
  assign tx_drop     = tx_push_req & tx_full & ~tx_pop;
  assign tx_unr      = tx_tready & tx_en & tx_empty;

  assign rx_pop      = rd_fire & (rd_sel == 2'd3) & ~rx_empty;
  assign rx_unf      = rd_fire & (rd_sel == 2'd3) & rx_empty;
  assign rx_push_req = rx_tvalid & rx_en;
  assign rx_push     = rx_push_req & (~rx_full | rx_pop) & ~rx_flush;
  assign rx_ovf      = rx_push_req & rx_full & ~rx_pop;

  assign sticky_clr  = (wr_fire && wr_sel == 2'd1 && S_AXI_WSTRB[0]) ? S_AXI_WDATA[7:4] : 4'b0;

  assign ctrl_word   = {17'b0, irq_thresh, 4'b0, rx_flush, tx_flush, rx_en, tx_en};
  assign status_word = {8'(rx_level), 8'(tx_level), 8'b0, sticky,
                        rx_full, rx_empty, tx_full, tx_empty};

  always_comb begin
    rd_word = '0;
    case (rd_sel)
      2'd0:    rd_word = ctrl_word;
      2'd1:    rd_word = status_word;
      2'd3:    rd_word = rx_empty ? 32'b0 : 32'(rx_mem[rx_rptr[AW-1:0]]);
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= S_AXI_WDATA[C_SAMPLE_WIDTH-1:0];
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= rx_tdata;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET || tx_flush) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      tx_wptr <= tx_wptr + (AW+1)'(tx_push);
      tx_rptr <= tx_rptr + (AW+1)'(tx_pop);
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET || rx_flush) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      rx_wptr <= rx_wptr + (AW+1)'(rx_push);
      rx_rptr <= rx_rptr + (AW+1)'(rx_pop);
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET || tx_flush || !tx_en) tx_tchan <= '0;
    else if (tx_pop) tx_tchan <= (tx_tchan == CW'(C_NUM_CH-1)) ? '0 : tx_tchan + 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      {rx_flush, tx_flush, rx_en, tx_en} <= '0;
      sticky <= '0;
    end else begin
      tx_flush <= 1'b0;
      rx_flush <= 1'b0;
      if (wr_fire && wr_sel == 2'd0 && S_AXI_WSTRB[0])
        {rx_flush, tx_flush, rx_en, tx_en} <= S_AXI_WDATA[3:0];
      // A new event in the same cycle as a clear keeps the bit set.
      sticky <= (sticky & ~sticky_clr) | {rx_unf, tx_drop, rx_ovf, tx_unr};
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
    end else begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      if (!S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID) begin
        S_AXI_AWREADY <= 1'b1;
        S_AXI_WREADY  <= 1'b1;
      end
      if (wr_fire) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= tx_drop ? 2'b10 : 2'b00;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= 2'b00;
    end else begin
      S_AXI_ARREADY <= !S_AXI_ARREADY && S_AXI_ARVALID && !S_AXI_RVALID;
      if (rd_fire) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_word;
        S_AXI_RRESP  <= rx_unf ? 2'b10 : 2'b00;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

`ifdef I2S_DATA_IRQ_EN
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      irq_thresh <= '0;
      irq        <= 1'b0;
    end else begin
      if (wr_fire && wr_sel == 2'd0 && S_AXI_WSTRB[1]) irq_thresh <= S_AXI_WDATA[14:8];
      irq <= (tx_en && (8'(tx_level) <= 8'(irq_thresh))) || (|sticky);
    end
  end
`else
  assign irq_thresh = '0;
  assign irq        = 1'b0;
`endif
endmodule
